// File: rtl/game_step_ctrl_if.sv
// Key, evaluator and history-store signals of the move/undo step controller.
// The controller side uses the slave modport; the stimulus side uses master.
interface game_step_ctrl_if;
    logic       key_valid;
    logic [2:0] key_code;
    logic       level_done;
    logic       mv_box_ok;
    logic       mv_man_ok;
    logic [1:0] dir;
    logic       eval_req;
    logic [1:0] sel;
    logic       state_en;
    logic [1:0] undo_left;
    logic [9:0] step_cnt;
    logic       busy;

    modport master (
        output key_valid, key_code, level_done, mv_box_ok, mv_man_ok,
        input  dir, eval_req, sel, state_en, undo_left, step_cnt, busy
    );

    modport slave (
        input  key_valid, key_code, level_done, mv_box_ok, mv_man_ok,
        output dir, eval_req, sel, state_en, undo_left, step_cnt, busy
    );
endinterface

// File: rtl/game_step_ctrl.sv
// Move/undo/restart sequencer for a box-pushing game: drives the move evaluator
// and the history store, and keeps the undo budget and committed step count.
module game_step_ctrl (
    input  logic               clk,
    input  logic               rst,
    game_step_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_EVAL   = 2'd2,
        ST_DECIDE = 2'd3
    } state_e;

    state_e      state_q;
    logic [1:0]  dir_q;
    logic [1:0]  sel_q;
    logic [1:0]  undo_left_q;
    logic [9:0]  step_cnt_q;
    logic        last_en_q;

    logic        key_dir_s;
    logic        key_undo_s;
    logic        key_restart_s;
    logic        init_load_s;
    logic        move_load_s;
    logic        undo_load_s;
    logic        state_en_s;
    logic [1:0]  sel_d;
    logic [1:0]  undo_left_d;
    logic [9:0]  step_cnt_d;

    // Key decode and history-store load selection; an undo right after a load is
    // dropped so that the load enable can never stay high for two cycles.
    always_comb begin
        key_dir_s     = bus.key_valid && (bus.key_code[2] == 1'b0) && !bus.level_done;
        key_undo_s    = bus.key_valid && (bus.key_code == 3'd4) && !bus.level_done;
        key_restart_s = bus.key_valid && (bus.key_code == 3'd5);
        init_load_s   = !rst && (state_q == ST_INIT);
        move_load_s   = !rst && (state_q == ST_DECIDE) && (bus.mv_box_ok || bus.mv_man_ok);
        undo_load_s   = !rst && (state_q == ST_IDLE) && key_undo_s &&
                        (undo_left_q != 2'd0) && !last_en_q;
        state_en_s    = init_load_s || move_load_s || undo_load_s;

        sel_d       = sel_q;
        undo_left_d = undo_left_q;
        step_cnt_d  = step_cnt_q;
        if (init_load_s) begin
            sel_d       = 2'd0;
            undo_left_d = 2'd0;
            step_cnt_d  = 10'd0;
        end else if (move_load_s) begin
            sel_d       = bus.mv_box_ok ? 2'd1 : 2'd2;
            undo_left_d = (undo_left_q == 2'd3) ? 2'd3 : undo_left_q + 2'd1;
            step_cnt_d  = (step_cnt_q >= 10'd999) ? 10'd999 : step_cnt_q + 10'd1;
        end else if (undo_load_s) begin
            sel_d       = 2'd3;
            undo_left_d = undo_left_q - 2'd1;
            step_cnt_d  = (step_cnt_q == 10'd0) ? 10'd0 : step_cnt_q - 10'd1;
        end else begin
            sel_d       = sel_q;
            undo_left_d = undo_left_q;
            step_cnt_d  = step_cnt_q;
        end
    end

    // Controller FSM together with the direction latch and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            dir_q       <= 2'd0;
            sel_q       <= 2'd0;
            undo_left_q <= 2'd0;
            step_cnt_q  <= 10'd0;
            last_en_q   <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            undo_left_q <= undo_left_d;
            step_cnt_q  <= step_cnt_d;
            last_en_q   <= state_en_s;
            case (state_q)
                ST_INIT: begin
                    state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (key_restart_s) begin
                        state_q <= ST_INIT;
                    end else if (key_dir_s) begin
                        dir_q   <= bus.key_code[1:0];
                        state_q <= ST_EVAL;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EVAL: begin
                    state_q <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Reset forces every output to its idle value even before the first clock edge.
    assign bus.dir       = rst ? 2'd0 : dir_q;
    assign bus.eval_req  = !rst && (state_q == ST_EVAL);
    assign bus.sel       = rst ? 2'd0 : sel_d;
    assign bus.state_en  = state_en_s;
    assign bus.undo_left = rst ? 2'd0 : undo_left_q;
    assign bus.step_cnt  = rst ? 10'd0 : step_cnt_q;
    assign bus.busy      = rst || (state_q != ST_IDLE);

endmodule

// File: tb/tb_game_step_ctrl.sv
// Bench for game_step_ctrl: directed scenarios with literal expectations, then
// random keys, all checked every cycle against a move/undo bookkeeping model.
module tb_game_step_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    game_step_ctrl_if bus();

    game_step_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the player has done so far, not how the controller sequences it.
    bit m_init  = 1'b1;
    int m_phase = 0;
    int m_dir   = 0;
    int m_undo  = 0;
    int m_step  = 0;
    int m_sel   = 0;
    bit m_last  = 1'b0;
    int e_dir, e_sel, e_undo, e_step;
    bit e_en, e_eval, e_busy;

    always @(negedge clk) begin
        e_dir = m_dir; e_sel = m_sel; e_undo = m_undo; e_step = m_step;
        e_en = 1'b0; e_eval = 1'b0; e_busy = 1'b1;
        if (rst) begin
            e_dir = 0; e_sel = 0; e_undo = 0; e_step = 0;
            m_init = 1'b1; m_phase = 0; m_dir = 0; m_undo = 0; m_step = 0; m_sel = 0;
        end else if (m_init) begin
            e_en = 1'b1; e_sel = 0;
            m_sel = 0; m_undo = 0; m_step = 0; m_init = 1'b0;
        end else if (m_phase == 1) begin
            e_eval = 1'b1;
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 0;
            if (bus.mv_box_ok || bus.mv_man_ok) begin
                e_en = 1'b1;
                e_sel = bus.mv_box_ok ? 1 : 2;
                m_sel = e_sel;
                m_undo = (m_undo + 1 > 3) ? 3 : m_undo + 1;
                m_step = (m_step + 1 > 999) ? 999 : m_step + 1;
            end
        end else begin
            e_busy = 1'b0;
            if (bus.key_valid) begin
                if (bus.key_code <= 3'd3 && !bus.level_done) begin
                    m_dir = int'(bus.key_code);
                    m_phase = 1;
                end else if (bus.key_code == 3'd4 && !bus.level_done && m_undo > 0 && !m_last) begin
                    e_en = 1'b1; e_sel = 3; m_sel = 3;
                    m_undo = m_undo - 1;
                    m_step = (m_step > 0) ? m_step - 1 : 0;
                end else if (bus.key_code == 3'd5) begin
                    m_init = 1'b1;
                end
            end
        end
        m_last = e_en;
        chk("outputs {dir,eval,sel,en,undo,step,busy}",
            {13'd0, bus.dir, bus.eval_req, bus.sel, bus.state_en, bus.undo_left, bus.step_cnt, bus.busy},
            {13'd0, e_dir[1:0], e_eval, e_sel[1:0], e_en, e_undo[1:0], e_step[9:0], e_busy});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_move(input logic [2:0] code);
        bus.key_valid = 1'b1; bus.key_code = code;
        tick();
        bus.key_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int exp_up[5] = '{1, 2, 3, 3, 3};
    int exp_dn[4] = '{2, 1, 0, 0};
    int n_en, n_ev;

    initial begin
        bus.key_valid = 1'b0; bus.key_code = 3'd0; bus.level_done = 1'b0;
        bus.mv_box_ok = 1'b0; bus.mv_man_ok = 1'b0;

        // Reset and release: one INIT load, then idle with cleared counters.
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", bus.busy, 1);
        chk("rst_state_en", bus.state_en, 0);
        chk("rst_step", bus.step_cnt, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("init_state_en", bus.state_en, 1);
        chk("init_sel", bus.sel, 0);
        tick();
        @(negedge clk);
        chk("idle_state_en", bus.state_en, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_undo", bus.undo_left, 0);
        chk("idle_step", bus.step_cnt, 0);

        // Right key with both results legal: box move wins.
        tick();
        bus.key_valid = 1'b1; bus.key_code = 3'd3; bus.mv_box_ok = 1'b1; bus.mv_man_ok = 1'b1;
        @(negedge clk);
        chk("key_cycle_eval", bus.eval_req, 0);
        chk("key_cycle_en", bus.state_en, 0);
        tick();
        bus.key_valid = 1'b0;
        @(negedge clk);
        chk("eval_req", bus.eval_req, 1);
        chk("eval_en", bus.state_en, 0);
        tick();
        @(negedge clk);
        chk("decide_en", bus.state_en, 1);
        chk("decide_sel", bus.sel, 1);
        chk("decide_dir", bus.dir, 3);
        chk("decide_eval", bus.eval_req, 0);
        tick();
        @(negedge clk);
        chk("move_step", bus.step_cnt, 1);
        chk("move_undo", bus.undo_left, 1);
        chk("sel_hold", bus.sel, 1);

        // Five man moves, then four undos (the last has nothing to retract).
        do_reset();
        bus.mv_box_ok = 1'b0; bus.mv_man_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_move(3'(i % 4));
            @(negedge clk);
            chk("undo_up", bus.undo_left, 32'(exp_up[i]));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.key_valid = 1'b1; bus.key_code = 3'd4;
            @(negedge clk);
            chk("undo_en", bus.state_en, (i < 3) ? 1 : 0);
            tick();
            bus.key_valid = 1'b0;
            @(negedge clk);
            chk("undo_dn", bus.undo_left, 32'(exp_dn[i]));
        end
        chk("undo_step_end", bus.step_cnt, 2);

        // Key held every cycle: one load per three cycles.
        tick();
        bus.key_valid = 1'b1; bus.key_code = 3'd0;
        n_en = 0; n_ev = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_en += int'(bus.state_en);
            n_ev += int'(bus.eval_req);
            tick();
        end
        bus.key_valid = 1'b0;
        chk("held_key_loads", n_en, 2);
        chk("held_key_evals", n_ev, 2);

        // Level solved: moves and undos ignored, restart still honoured.
        bus.level_done = 1'b1;
        bus.key_valid = 1'b1; bus.key_code = 3'd0;
        n_en = 0; n_ev = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_en += int'(bus.state_en);
            n_ev += int'(bus.eval_req);
            tick();
            bus.key_valid = 1'b0;
        end
        chk("done_no_eval", n_ev, 0);
        chk("done_no_load", n_en, 0);
        bus.key_valid = 1'b1; bus.key_code = 3'd4;
        @(negedge clk);
        chk("done_undo_en", bus.state_en, 0);
        tick();
        bus.key_code = 3'd5;
        @(negedge clk);
        chk("restart_key_en", bus.state_en, 0);
        tick();
        bus.key_valid = 1'b0;
        @(negedge clk);
        chk("restart_init_en", bus.state_en, 1);
        chk("restart_init_sel", bus.sel, 0);
        tick();
        @(negedge clk);
        chk("restart_undo", bus.undo_left, 0);
        chk("restart_step", bus.step_cnt, 0);
        bus.level_done = 1'b0;

        // Saturation after 1000 moves, then reset during DECIDE.
        for (int i = 0; i < 1000; i++) begin
            do_move(3'(i % 4));
        end
        @(negedge clk);
        chk("sat_step", bus.step_cnt, 999);
        chk("sat_undo", bus.undo_left, 3);
        chk("model_sat_step", m_step, 999);
        chk("model_sat_undo", m_undo, 3);
        tick();
        bus.key_valid = 1'b1; bus.key_code = 3'd2;
        tick();
        bus.key_valid = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_en", bus.state_en, 0);
        chk("abort_sel", bus.sel, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_init_en", bus.state_en, 1);
        chk("abort_init_sel", bus.sel, 0);
        tick();
        @(negedge clk);
        chk("abort_step", bus.step_cnt, 0);
        chk("abort_busy", bus.busy, 0);

        // Random traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst            = ($urandom_range(0, 199) == 0);
            bus.key_valid  = ($urandom_range(0, 2) == 0);
            bus.key_code   = 3'($urandom_range(0, 7));
            bus.level_done = ($urandom_range(0, 9) == 0);
            bus.mv_box_ok  = ($urandom_range(0, 3) == 0);
            bus.mv_man_ok  = ($urandom_range(0, 1) == 0);
        end
        tick();
        rst = 1'b0; bus.key_valid = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/game_step_ctrl.md
GAME_STEP_CTRL -- requirements
Module: game_step_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
REQ-004 key_code  input  3  0=up, 1=down, 2=left, 3=right, 4=undo, 5=restart, 6-7 reserved (ignored).
REQ-005 level_done  input  1  level-solved flag from the win checker.
REQ-006 mv_box_ok  input  1  evaluator result: push-box move legal; valid the cycle after eval_req.
REQ-007 mv_man_ok  input  1  evaluator result: plain man move legal; valid the cycle after eval_req.
REQ-008 dir  output  2  latched move direction presented to the evaluator.
REQ-009 eval_req  output  1  one-cycle request to the evaluator.
REQ-010 sel  output  2  history-store select: 0=initial, 1=box move, 2=man move, 3=retract.
REQ-011 state_en  output  1  one-cycle history-store load enable.
REQ-012 undo_left  output  2  retracts currently available, 0-3.
REQ-013 step_cnt  output  10  committed-move counter, 0-999.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states SHALL be INIT, IDLE, EVAL, DECIDE; only IDLE accepts keys.
REQ-016 INIT SHALL drive sel=0 and state_en=1 for exactly one cycle, clear undo_left and step_cnt, then go to IDLE.
REQ-017 A key_valid pulse outside IDLE SHALL be dropped, with no queueing.
REQ-018 IDLE with a direction key (0-3) and level_done=0 SHALL latch dir=key_code[1:0] and go to EVAL.
REQ-019 EVAL SHALL assert eval_req for one cycle and go to DECIDE.
REQ-020 DECIDE SHALL sample the mv_* inputs and go to IDLE.
REQ-021 In DECIDE with mv_box_ok=1: sel=1 and state_en=1; box takes priority over man.
REQ-022 In DECIDE with mv_box_ok=0 and mv_man_ok=1: sel=2 and state_en=1.
REQ-023 In DECIDE with both results 0: state_en=0 and no counter change.
REQ-024 A committed move SHALL increment undo_left, saturating at 3, and increment step_cnt, saturating at 999.
REQ-025 IDLE with undo (4), undo_left>0 and level_done=0 SHALL drive sel=3 and state_en=1 in the same cycle as the key.
REQ-026 The undo of REQ-025 SHALL decrement undo_left and decrement step_cnt (floor 0), staying in IDLE.
REQ-027 Undo with undo_left=0 SHALL be ignored: state_en stays 0 and counters are unchanged.
REQ-028 IDLE with restart (5) SHALL go to INIT regardless of level_done.
REQ-029 With level_done=1, direction and undo keys SHALL be ignored.
REQ-030 state_en SHALL never be high on two consecutive cycles.
REQ-031 sel SHALL hold its last value when state_en=0.
REQ-032 Key-to-load latency SHALL be 3 cycles for a move (key cycle, EVAL, DECIDE with load) and 1 cycle for an undo.
REQ-033 All outputs SHALL be registered or decoded from registered FSM state only, with no combinational path from key inputs except the REQ-025 undo load.

Reset
REQ-034 While rst=1: state=INIT, dir=0, sel=0, eval_req=0, state_en=0, undo_left=0, step_cnt=0, busy=1.
REQ-035 The first cycle after rst deasserts SHALL perform the INIT load (sel=0, state_en=1).
REQ-036 rst asserted in EVAL or DECIDE SHALL abort the move: no load occurs and the block re-enters INIT.

Verification
REQ-037 Reset release: single pulse state_en=1, sel=0; then busy=0, undo_left=0, step_cnt=0.
REQ-038 Key 3 with mv_box_ok=1, mv_man_ok=1 in DECIDE: eval_req high 1 cycle, then sel=1, state_en=1 on cycle 3, dir=3, step_cnt=1, undo_left=1.
REQ-039 Five legal man moves then four undos: undo_left sequence 1,2,3,3,3 then 2,1,0,0; fourth undo produces no state_en; step_cnt ends at 2.
REQ-040 Key pulses on every cycle of a move: only the first is honoured; total exactly one state_en pulse per 3 cycles.
REQ-041 level_done=1: keys 0 and 4 produce no eval_req or state_en; key 5 produces the INIT load and clears both counters.
REQ-042 Counter saturation: 1000 legal moves leave step_cnt=999 and undo_left=3; rst asserted during DECIDE yields no sel=1/2 load.
